turf_udp_hsk_ingress_filter: RTL
================================

Name: turf_udp_hsk_ingress_filter

Overview:
- Sits directly upstream of the housekeeping UDP read path. Takes the header/data streams from the UDP port demux and forwards them as-is to the hsk read stage's s_udphdr_/s_udpdata_ ports.
- Drops packets that are malformed, oversize, or arrive while housekeeping is still busy. Enforces the header length field on the data stream so the downstream FIFO never sees a mismatched packet.
- Keeps saturating drop and length-error counters for status readback.

Parameters:
- MAX_BYTES, 1024: largest accepted payload length in bytes; must be ≤ 65535.
- CNT_WIDTH, 16: width of the saturating status counters.

Ports:
- aclk  in  1  stream clock.
- areset  in  1  asynchronous active-high reset.
- hsk_busy_i  in  1  high while the downstream hsk IRQ is pending and not yet completed; sampled at header accept.
- s_udphdr_tdata  in  64  [63:32] source IP, [31:16] source port, [15:0] payload length in bytes.
- s_udphdr_tvalid  in  1
- s_udphdr_tready  out  1
- s_udpdata_tdata  in  64
- s_udpdata_tkeep  in  8
- s_udpdata_tlast  in  1
- s_udpdata_tvalid  in  1
- s_udpdata_tready  out  1
- m_udphdr_tdata  out  64  registered copy of the accepted header.
- m_udphdr_tvalid  out  1
- m_udphdr_tready  in  1
- m_udpdata_tdata  out  64
- m_udpdata_tkeep  out  8
- m_udpdata_tlast  out  1
- m_udpdata_tvalid  out  1
- m_udpdata_tready  in  1
- drop_count_o  out  CNT_WIDTH  packets dropped (bad length or busy); saturates at all-ones.
- len_err_count_o  out  CNT_WIDTH  forwarded packets whose tlast position disagreed with the length field; saturates.

Behaviour:
- Reset (asynchronous, areset=1):
  - state=IDLE.
  - All tvalid and tready outputs 0.
  - m_udphdr_tdata=0.
  - Both counters 0.
  - Beat counter 0.
- State IDLE:
  - s_udphdr_tready=1; all other handshakes 0.
  - On header handshake, register the header. Compute exp_beats = ceil(len/8) as a 14-bit value (len+7)>>3.
  - Drop if len==0, len>MAX_BYTES, or hsk_busy_i==1 in the accept cycle: go to DROP and increment drop_count.
  - Otherwise go to HDR.
- State HDR:
  - m_udphdr_tvalid=1 holding the registered header; s_udpdata_tready=0.
  - On m_udphdr_tready, go to PASS with beat=0.
- State PASS:
  - Combinational pass-through: m_udpdata_tvalid=s_udpdata_tvalid, s_udpdata_tready=m_udpdata_tready; tdata and tkeep unmodified.
  - beat increments on each data handshake.
  - Final expected beat (beat==exp_beats-1):
    - m_udpdata_tlast forced to 1.
    - If the input tlast is also 1: go to IDLE.
    - Otherwise (long packet): increment len_err_count and go to DROP to discard the remainder.
  - Input tlast before the final expected beat (short packet): forward it with tlast=1, increment len_err_count, go to IDLE.
  - No output beat is ever emitted after a forced tlast.
- State DROP:
  - s_udpdata_tready=1; m_* tvalid=0.
  - Consume beats until a tlast handshake, then go to IDLE.
- Latency:
  - Header: 1 cycle from accept to m_udphdr_tvalid.
  - Data: 0 cycles, combinational in PASS.
- The header for packet N+1 is not accepted until packet N's data is fully drained (strict one-packet-in-flight).
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Simultaneous drop and len_err increments cannot occur, because they fire in different states.
- Reset mid-packet: state returns to IDLE and all valids drop immediately. The upstream remainder of that packet is then treated as a new stream; the upstream demux is reset on the same areset, so this is acceptable.
- MAX_BYTES boundary: len==MAX_BYTES is accepted; len==MAX_BYTES+1 is dropped.

Decomposition:
- Shared package turf_udp_pkg holds:
  - header field offsets: IP_LSB=32, PORT_LSB=16, LEN_LSB=0, LEN_W=16;
  - the state enum {IDLE, HDR, PASS, DROP};
  - a function for bytes-to-beats.
- No sub-module. The saturating counter is a small function or generate in the package. Skid buffering is not required because data is pass-through.

Test Plan:
- Header len=24, busy=0, 3 data beats, tlast on beat 3, random m_tready → header out 1 cycle after accept; 3 beats out identical; tlast on beat 3; counters 0.
- len=0, then len=1025 (MAX_BYTES=1024) → both dropped, their data fully consumed (tready=1), nothing on m_*, drop_count=2.
- len=16, hsk_busy_i=1 at accept → dropped, drop_count=1. Next packet with busy=0 and len=8, 1 beat → forwarded.
- len=16, input sends 4 beats with tlast on beat 4 → 2 beats out, tlast forced on beat 2, beats 3-4 absorbed, len_err_count=1, IDLE afterwards.
- len=32, input tlast on beat 2 → 2 beats out with tlast on beat 2, len_err_count=1, next header accepted next cycle.
- areset asserted mid-PASS → all valids 0 and counters 0 asynchronously; after release, s_udphdr_tready=1 and a clean len=8 packet forwards correctly. Separately, force 2^16+5 drops → drop_count holds 0xFFFF.

Source files
------------

// File: rtl/turf_udp_pkg.sv
// Shared definitions for the TURF UDP housekeeping ingress path: header layout,
// filter state encoding and small arithmetic helpers.
package turf_udp_pkg;

    localparam int unsigned HDR_W    = 64;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned KEEP_W   = 8;
    localparam int unsigned IP_LSB   = 32;
    localparam int unsigned PORT_LSB = 16;
    localparam int unsigned LEN_LSB  = 0;
    localparam int unsigned LEN_W    = 16;
    localparam int unsigned BEAT_W   = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PASS = 2'd2,
        DROP = 2'd3
    } state_t;

    typedef struct packed {
        logic [HDR_W-IP_LSB-1:0]     src_ip;
        logic [IP_LSB-PORT_LSB-1:0]  src_port;
        logic [PORT_LSB-LEN_LSB-1:0] len;
    } udp_hdr_t;

    // ceil(len/8) in 8-byte beats; a 16-bit length needs at most 14 bits of beats.
    function automatic logic [BEAT_W-1:0] bytes_to_beats(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = (LEN_W+1)'(len) + (LEN_W+1)'(7);
        return BEAT_W'(sum >> 3);
    endfunction

    // Increment that sticks at the all-ones value of a 'width'-bit counter (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] top;
        top = 32'hFFFF_FFFF >> (32 - width);
        return (val >= top) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/turf_udp_hsk_ingress_filter.sv
// Housekeeping UDP ingress filter: drops malformed/oversize/busy packets and trims
// the data stream to the header length, one packet in flight at a time.
module turf_udp_hsk_ingress_filter
    import turf_udp_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 1024,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 hsk_busy_i,

    input  logic [HDR_W-1:0]     s_udphdr_tdata,
    input  logic                 s_udphdr_tvalid,
    output logic                 s_udphdr_tready,

    input  logic [DATA_W-1:0]    s_udpdata_tdata,
    input  logic [KEEP_W-1:0]    s_udpdata_tkeep,
    input  logic                 s_udpdata_tlast,
    input  logic                 s_udpdata_tvalid,
    output logic                 s_udpdata_tready,

    output logic [HDR_W-1:0]     m_udphdr_tdata,
    output logic                 m_udphdr_tvalid,
    input  logic                 m_udphdr_tready,

    output logic [DATA_W-1:0]    m_udpdata_tdata,
    output logic [KEEP_W-1:0]    m_udpdata_tkeep,
    output logic                 m_udpdata_tlast,
    output logic                 m_udpdata_tvalid,
    input  logic                 m_udpdata_tready,

    output logic [CNT_WIDTH-1:0] drop_count_o,
    output logic [CNT_WIDTH-1:0] len_err_count_o
);

    state_t              r_state;
    state_t              w_state_nxt;
    udp_hdr_t            r_hdr;
    udp_hdr_t            w_hdr_in;
    logic [BEAT_W-1:0]   r_exp_beats;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_live;
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic [CNT_WIDTH-1:0] r_len_err_cnt;

    logic w_reject;
    logic w_final_beat;
    logic w_hdr_load;
    logic w_beat_clr;
    logic w_beat_inc;
    logic w_drop_inc;
    logic w_len_err_inc;

    assign w_hdr_in     = udp_hdr_t'(s_udphdr_tdata);
    assign w_reject     = (w_hdr_in.len == '0) || (32'(w_hdr_in.len) > MAX_BYTES) || hsk_busy_i;
    assign w_final_beat = (r_beat == (r_exp_beats - BEAT_W'(1)));

    assign m_udphdr_tdata  = r_hdr;
    assign m_udpdata_tdata = s_udpdata_tdata;
    assign m_udpdata_tkeep = s_udpdata_tkeep;
    assign drop_count_o    = r_drop_cnt;
    assign len_err_count_o = r_len_err_cnt;

    // Next-state and handshake decode; r_live holds header tready low until the first edge after reset.
    always_comb begin
        w_state_nxt      = r_state;
        s_udphdr_tready  = 1'b0;
        s_udpdata_tready = 1'b0;
        m_udphdr_tvalid  = 1'b0;
        m_udpdata_tvalid = 1'b0;
        m_udpdata_tlast  = 1'b0;
        w_hdr_load       = 1'b0;
        w_beat_clr       = 1'b0;
        w_beat_inc       = 1'b0;
        w_drop_inc       = 1'b0;
        w_len_err_inc    = 1'b0;

        case (r_state)
            IDLE: begin
                s_udphdr_tready = r_live;
                if (s_udphdr_tvalid && r_live) begin
                    w_hdr_load = 1'b1;
                    if (w_reject) begin
                        w_state_nxt = DROP;
                        w_drop_inc  = 1'b1;
                    end else begin
                        w_state_nxt = HDR;
                    end
                end
            end
            HDR: begin
                m_udphdr_tvalid = 1'b1;
                if (m_udphdr_tready) begin
                    w_state_nxt = PASS;
                    w_beat_clr  = 1'b1;
                end
            end
            PASS: begin
                m_udpdata_tvalid = s_udpdata_tvalid;
                s_udpdata_tready = m_udpdata_tready;
                m_udpdata_tlast  = s_udpdata_tlast || w_final_beat;
                if (s_udpdata_tvalid && m_udpdata_tready) begin
                    w_beat_inc = 1'b1;
                    if (w_final_beat) begin
                        // Long packet: the remainder after the forced tlast is discarded.
                        if (s_udpdata_tlast) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt   = DROP;
                            w_len_err_inc = 1'b1;
                        end
                    end else if (s_udpdata_tlast) begin
                        w_state_nxt   = IDLE;
                        w_len_err_inc = 1'b1;
                    end
                end
            end
            DROP: begin
                s_udpdata_tready = 1'b1;
                if (s_udpdata_tvalid && s_udpdata_tlast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, header capture, beat tracking and saturating status counters.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= IDLE;
            r_hdr         <= '0;
            r_exp_beats   <= '0;
            r_beat        <= '0;
            r_live        <= 1'b0;
            r_drop_cnt    <= '0;
            r_len_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_hdr_load) begin
                r_hdr       <= w_hdr_in;
                r_exp_beats <= bytes_to_beats(w_hdr_in.len);
            end
            if (w_beat_clr) begin
                r_beat <= '0;
            end else if (w_beat_inc) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
            if (w_drop_inc) begin
                r_drop_cnt <= CNT_WIDTH'(sat_inc(32'(r_drop_cnt), CNT_WIDTH));
            end
            if (w_len_err_inc) begin
                r_len_err_cnt <= CNT_WIDTH'(sat_inc(32'(r_len_err_cnt), CNT_WIDTH));
            end
        end
    end

endmodule
